dcache_dm_wt: RTL and testbench
===============================

Name: dcache_dm_wt

Overview:
Parametrised direct-mapped, write-through, no-write-allocate data cache between the core load/store unit and the memory bus.
- Core side: valid/ready request port plus a one-cycle response pulse.
- Memory side: single-outstanding request/response port; a read miss refills a whole multi-word line.
- Adds a tag compare, line refill, write-through and a whole-cache flush.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width in bits; power of 2, at least 8
NUM_LINES, 32, number of cache lines; power of 2
LINE_WORDS, 4, words per line; power of 2, at least 2

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, synchronous, active-low (0 = reset)
flush  in  1  invalidate all lines; sampled in IDLE only
req_valid  in  1  core request valid
req_ready  out  1  core request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address, word aligned
req_wdata  in  DATA_W  store data
resp_valid  out  1  one-cycle response pulse; no backpressure
resp_rdata  out  DATA_W  load data; 0 for stores
resp_hit  out  1  request hit in cache
resp_line  out  log2(NUM_LINES)  line index used
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  memory write
mem_req_addr  out  ADDR_W  memory word address
mem_req_wdata  out  DATA_W  memory write data
mem_resp_valid  in  1  read data valid
mem_resp_rdata  in  DATA_W  read data

Behaviour:
- Address split, LSB upward:
  - BOFF = log2(DATA_W/8) bits, ignored.
  - OFF = log2(LINE_WORDS) bits.
  - IDX = log2(NUM_LINES) bits.
  - TAG = the remaining upper bits.
- Storage: valid bit per line in flops; tag and data arrays with registered read.
- FSM states: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, WR_MEM, RESP.
- IDLE:
  - req_ready = !flush.
  - flush=1 clears every valid bit in one cycle and stays in IDLE. Flush has priority over a simultaneous req_valid; that request is not accepted.
  - On accept, latch we/addr/wdata and go to LOOKUP.
- LOOKUP: hit = valid[IDX] && tag[IDX] == TAG.
  - Load hit → RESP.
  - Load miss → REFILL_REQ with word counter = 0.
  - Store hit → write wdata into the data array this cycle, then WR_MEM.
  - Store miss → WR_MEM, cache unchanged.
- REFILL_REQ:
  - Drive mem_req_valid=1, we=0, addr = {TAG, IDX, counter, BOFF zeros}.
  - Hold all mem_req_* stable until mem_req_ready, then go to REFILL_WAIT.
- REFILL_WAIT:
  - On mem_resp_valid, write the word into data[IDX][counter]. If the word offset equals the request OFF, capture it for the response.
  - If counter == LINE_WORDS-1: set valid[IDX], write tag, go to RESP. Otherwise increment counter and return to REFILL_REQ.
  - Words are requested in ascending order from offset 0; one request outstanding at a time.
- WR_MEM: mem_req_valid=1, we=1, addr = latched address, wdata = latched data; hold until mem_req_ready, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - resp_hit = the LOOKUP hit result; resp_line = IDX.
  - resp_rdata = load data, or 0 for stores.
- Latency, accept cycle = N:
  - Load hit: resp_valid in cycle N+2.
  - Load miss: N+2 + LINE_WORDS × (request handshake + response latency).
- mem_resp_valid outside REFILL_WAIT is ignored.
- Reset (reset=0 at a clock edge):
  - State = IDLE; all valid bits = 0; counter = 0.
  - All outputs = 0, except req_ready, which is 0 during reset and 1 in the first IDLE cycle after it.
  - Reset mid-refill abandons the line, which stays invalid.
  - Data and tag arrays are not cleared.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0]. Exactly one of them increments per accepted request, in its LOOKUP cycle. Both wrap at 2^32, reset to 0, and are not cleared by flush.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dcache_pkg: FSM state enum, plus localparam helper functions for BOFF/OFF/IDX/TAG widths derived from the parameters.
- Sub-module dcache_data_ram: data array with registered read and single write port, NUM_LINES*LINE_WORDS words × DATA_W. Tags live in the top level.

Test Plan:
Test configuration is default parameters: 16-byte lines, 512-byte cache; IDX = addr[8:4].
1. Cold load 0x40 → four memory reads 0x40, 0x44, 0x48, 0x4C in order; resp_rdata = memory word at 0x40; resp_hit = 0; resp_line = 4.
2. Load 0x44 after case 1 → no memory traffic; resp_valid exactly 2 cycles after accept; resp_hit = 1; correct data.
3. Load 0x240 (index 4, different tag) then load 0x40 → both miss, each with a 4-word refill; stall mem_req_ready for 3 cycles and check that the mem_req_* outputs are held stable.
4. Store 0x48 = 0xDEADBEEF on a hit:
   - expect a memory write to 0x48 and resp_rdata = 0;
   - a following load of 0x48 hits and returns 0xDEADBEEF.
   Store 0x1000 on a miss:
   - expect a memory write only;
   - a following load of 0x1000 misses.
5. flush=1 with req_valid=1 in the same cycle → req_ready = 0 and the request is not accepted; afterwards a load of 0x40 misses.
6. reset=0 during REFILL_WAIT, with a stray mem_resp_valid afterwards → FSM returns to IDLE and the stray response is ignored; a load of 0x40 then misses. With DCACHE_STATS_EN defined, check the hit/miss counts over cases 1–4.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_WAIT,
    WR_MEM,
    RESP
  } state_e;

  function automatic int boff_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w,
                               input int num_lines, input int line_words);
    return addr_w - boff_w(data_w) - off_w(line_words) - idx_w(num_lines);
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Cache data array: one synchronous write port and one registered read port.
module dcache_data_ram #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: storage arrays carry no reset; contents are meaningless until a line is marked valid.
  always_ff @(posedge clk) begin
    if (we_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with whole-line refill.
// Define DCACHE_STATS_EN to add hit_count / miss_count outputs.
module dcache_dm_wt
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_hit,
  output logic [$clog2(NUM_LINES)-1:0] resp_line,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_we,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [DATA_W-1:0]            mem_req_wdata,
  input  logic                         mem_resp_valid,
  input  logic [DATA_W-1:0]            mem_resp_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
`endif
);

  localparam int BOFF_W = boff_w(DATA_W);
  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_W, DATA_W, NUM_LINES, LINE_WORDS);
  localparam int RAM_AW = IDX_W + OFF_W;

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic                  hit_q, hit_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic [TAG_W-1:0]      tag_mem [NUM_LINES];
  logic [TAG_W-1:0]      tag_rd_q;
  logic                  tag_we;

  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_waddr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  logic [IDX_W-1:0]      req_idx, lat_idx;
  logic [OFF_W-1:0]      req_off, lat_off;
  logic [TAG_W-1:0]      lat_tag;
  logic                  accept, lookup_hit;
  logic [ADDR_W-1:0]     refill_addr;

  assign req_idx = req_addr[BOFF_W+OFF_W +: IDX_W];
  assign req_off = req_addr[BOFF_W +: OFF_W];
  assign lat_idx = addr_q[BOFF_W+OFF_W +: IDX_W];
  assign lat_off = addr_q[BOFF_W +: OFF_W];
  assign lat_tag = addr_q[ADDR_W-1 -: TAG_W];

  assign accept     = (state_q == IDLE) && !flush && req_valid;
  assign lookup_hit = valid_q[lat_idx] && (tag_rd_q == lat_tag);

  // Array reads are issued in the accept cycle so tag and data are ready in LOOKUP.
  dcache_data_ram #(
    .DEPTH  (NUM_LINES * LINE_WORDS),
    .DATA_W (DATA_W)
  ) u_data_ram (
    .clk       (clk),
    .rd_en_i   (accept),
    .rd_addr_i ({req_idx, req_off}),
    .rd_data_o (ram_rdata),
    .we_i      (ram_we),
    .wr_addr_i (ram_waddr),
    .wr_data_i (ram_wdata)
  );

  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[lat_idx] <= lat_tag;
    if (accept) tag_rd_q <= tag_mem[req_idx];
  end

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    hit_d     = hit_q;
    rdata_d   = rdata_q;
    tag_we    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = {lat_idx, lat_off};
    ram_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        hit_d = lookup_hit;
        if (we_q) begin
          rdata_d = '0;
          ram_we  = lookup_hit;
          state_d = WR_MEM;
        end else if (lookup_hit) begin
          rdata_d = ram_rdata;
          state_d = RESP;
        end else begin
          cnt_d   = '0;
          state_d = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        if (mem_req_ready) state_d = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (mem_resp_valid) begin
          ram_we    = 1'b1;
          ram_waddr = {lat_idx, cnt_q};
          ram_wdata = mem_resp_rdata;
          if (cnt_q == lat_off) rdata_d = mem_resp_rdata;
          if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
            valid_d[lat_idx] = 1'b1;
            tag_we           = 1'b1;
            cnt_d            = '0;
            state_d          = RESP;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = REFILL_REQ;
          end
        end
      end
      WR_MEM: begin
        if (mem_req_ready) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and active-low; all state updates use non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    refill_addr = '0;
    refill_addr[ADDR_W-1:BOFF_W] = {addr_q[ADDR_W-1:BOFF_W+OFF_W], cnt_q};
  end

  always_comb begin
    req_ready     = (state_q == IDLE) && !flush;
    mem_req_valid = (state_q == REFILL_REQ) || (state_q == WR_MEM);
    mem_req_we    = (state_q == WR_MEM);
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    resp_valid    = (state_q == RESP);
    resp_rdata    = '0;
    resp_hit      = 1'b0;
    resp_line     = '0;
    if (state_q == REFILL_REQ) mem_req_addr = refill_addr;
    if (state_q == WR_MEM) begin
      mem_req_addr  = addr_q;
      mem_req_wdata = wdata_q;
    end
    if (state_q == RESP) begin
      resp_rdata = rdata_q;
      resp_hit   = hit_q;
      resp_line  = lat_idx;
    end
    // Outputs are held quiet while reset is asserted, whatever the state register holds.
    if (!reset) begin
      req_ready     = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_we    = 1'b0;
      mem_req_addr  = '0;
      mem_req_wdata = '0;
      resp_valid    = 1'b0;
      resp_rdata    = '0;
      resp_hit      = 1'b0;
      resp_line     = '0;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (lookup_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else            miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Directed bench for dcache_dm_wt at default parameters (16-byte lines, index = addr[8:4]).
module tb_dcache_dm_wt;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_hit;
  logic [4:0]  resp_line;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_rdata = '0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_dm_wt dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_hit       (resp_hit),
    .resp_line      (resp_line),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Backing memory: unwritten words read as a recognisable address pattern.
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] lg_addr [$];
  logic        lg_we   [$];
  logic [31:0] lg_data [$];
  int          stall_cycles = 0;
  int          wait_cnt = 0;
  int          unstable_cnt = 0;
  logic        stray_resp = 1'b0;
  logic        snap_we;
  logic [31:0] snap_addr, snap_data;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory-bus slave: acts 2 time units after each rising edge, one response cycle after a read handshake.
  always begin
    @(posedge clk);
    #2;
    mem_resp_valid = 1'b0;
    if (!reset) begin
      mem_req_ready = 1'b0;
      wait_cnt      = 0;
    end else begin
      if (stray_resp) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hBAD0_BAD0;
        stray_resp     = 1'b0;
      end
      if (mem_req_ready) begin
        mem_req_ready = 1'b0;
        wait_cnt      = 0;
        lg_addr.push_back(snap_addr);
        lg_we.push_back(snap_we);
        lg_data.push_back(snap_data);
        if (snap_we) begin
          mem_arr[snap_addr] = snap_data;
        end else begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = mem_rd(snap_addr);
        end
      end else if (mem_req_valid) begin
        if (wait_cnt == 0) begin
          snap_we   = mem_req_we;
          snap_addr = mem_req_addr;
          snap_data = mem_req_wdata;
        end else if ({mem_req_we, mem_req_addr, mem_req_wdata} !== {snap_we, snap_addr, snap_data}) begin
          unstable_cnt++;
        end
        if (wait_cnt >= stall_cycles) mem_req_ready = 1'b1;
        else wait_cnt++;
      end
    end
  end

  task automatic clear_log();
    lg_addr.delete();
    lg_we.delete();
    lg_data.delete();
  endtask

  // Issues one request; lat counts cycles from accept to resp_valid (-1 on timeout).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic hit, output logic [4:0] line,
                        output int lat, output logic pulse_ok);
    int guard;
    rd = '0; hit = 1'b0; line = '0; lat = -1; pulse_ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    #1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (resp_valid) begin
        lat = k; rd = resp_rdata; hit = resp_hit; line = resp_line;
        @(negedge clk);
        pulse_ok = !resp_valid;
        return;
      end
      @(negedge clk);
    end
  endtask

  logic [31:0] rd;
  logic        hit, pulse_ok;
  logic [4:0]  line;
  int          lat;

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b expected 0", req_ready); end
    n_cmp++; if ({mem_req_valid, resp_valid} !== 2'b00) begin n_bad++; $display("FAIL reset_valids: got %b expected 00", {mem_req_valid, resp_valid}); end
    reset = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_first_idle: got %b expected 1", req_ready); end
`ifdef DCACHE_STATS_EN
    n_cmp++; if ({hit_count, miss_count} !== 64'd0) begin n_bad++; $display("FAIL reset_stats: got %h expected 0", {hit_count, miss_count}); end
`endif
  endtask

  task automatic test_cold_load();
    clear_log();
    do_req(1'b0, 32'h40, '0, rd, hit, line, lat, pulse_ok);
    n_cmp++; if (rd !== 32'hC0DE0040) begin n_bad++; $display("FAIL cold_rdata: got %h expected %h", rd, 32'hC0DE0040); end
    n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL cold_hit: got %b expected 0", hit); end
    n_cmp++; if (line !== 5'd4) begin n_bad++; $display("FAIL cold_line: got %0d expected 4", line); end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL cold_latency: got %0d expected 10", lat); end
    n_cmp++; if (pulse_ok !== 1'b1) begin n_bad++; $display("FAIL cold_pulse: got %b expected 1", pulse_ok); end
    n_cmp++; if (lg_addr.size() !== 4) begin n_bad++; $display("FAIL cold_nreads: got %0d expected 4", lg_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < lg_addr.size()) begin
        n_cmp++;
        if ({lg_we[i], lg_addr[i]} !== {1'b0, 32'h40 + 32'(4 * i)}) begin
          n_bad++; $display("FAIL cold_read%0d: got we=%b addr=%h expected we=0 addr=%h", i, lg_we[i], lg_addr[i], 32'h40 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_load_hit();
    clear_log();
    do_req(1'b0, 32'h44, '0, rd, hit, line, lat, pulse_ok);
    n_cmp++; if (rd !== 32'hC0DE0044) begin n_bad++; $display("FAIL hit_rdata: got %h expected %h", rd, 32'hC0DE0044); end
    n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL hit_flag: got %b expected 1", hit); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL hit_latency: got %0d expected 2", lat); end
    n_cmp++; if (lg_addr.size() !== 0) begin n_bad++; $display("FAIL hit_traffic: got %0d expected 0", lg_addr.size()); end
  endtask

  task automatic test_conflict_stall();
    stall_cycles = 3;
    unstable_cnt = 0;
    clear_log();
    do_req(1'b0, 32'h240, '0, rd, hit, line, lat, pulse_ok);
    n_cmp++; if ({hit, line, rd} !== {1'b0, 5'd4, 32'hC0DE0240}) begin n_bad++; $display("FAIL conf240: got hit=%b line=%0d rd=%h expected 0 4 c0de0240", hit, line, rd); end
    n_cmp++; if (lat !== 22) begin n_bad++; $display("FAIL conf240_latency: got %0d expected 22", lat); end
    n_cmp++; if (lg_addr.size() !== 4) begin n_bad++; $display("FAIL conf240_nreads: got %0d expected 4", lg_addr.size()); end
    else begin
      n_cmp++; if (lg_addr[3] !== 32'h24C) begin n_bad++; $display("FAIL conf240_last: got %h expected 0000024c", lg_addr[3]); end
    end
    do_req(1'b0, 32'h40, '0, rd, hit, line, lat, pulse_ok);
    n_cmp++; if ({hit, rd} !== {1'b0, 32'hC0DE0040}) begin n_bad++; $display("FAIL conf040: got hit=%b rd=%h expected 0 c0de0040", hit, rd); end
    n_cmp++; if (lat !== 22) begin n_bad++; $display("FAIL conf040_latency: got %0d expected 22", lat); end
    n_cmp++; if (unstable_cnt !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes expected 0", unstable_cnt); end
    stall_cycles = 0;
  endtask

  task automatic test_store();
    clear_log();
    do_req(1'b1, 32'h48, 32'hDEADBEEF, rd, hit, line, lat, pulse_ok);
    n_cmp++; if ({hit, line, rd} !== {1'b1, 5'd4, 32'h0}) begin n_bad++; $display("FAIL st_hit_resp: got hit=%b line=%0d rd=%h expected 1 4 0", hit, line, rd); end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL st_hit_latency: got %0d expected 3", lat); end
    n_cmp++; if (lg_addr.size() !== 1) begin n_bad++; $display("FAIL st_hit_nwr: got %0d expected 1", lg_addr.size()); end
    else begin
      n_cmp++; if ({lg_we[0], lg_addr[0], lg_data[0]} !== {1'b1, 32'h48, 32'hDEADBEEF}) begin n_bad++; $display("FAIL st_hit_bus: got we=%b a=%h d=%h expected 1 48 deadbeef", lg_we[0], lg_addr[0], lg_data[0]); end
    end
    clear_log();
    do_req(1'b0, 32'h48, '0, rd, hit, line, lat, pulse_ok);
    n_cmp++; if ({hit, rd} !== {1'b1, 32'hDEADBEEF}) begin n_bad++; $display("FAIL ld_after_st: got hit=%b rd=%h expected 1 deadbeef", hit, rd); end
    n_cmp++; if (lg_addr.size() !== 0) begin n_bad++; $display("FAIL ld_after_st_traffic: got %0d expected 0", lg_addr.size()); end
    clear_log();
    do_req(1'b1, 32'h1000, 32'h1234_5678, rd, hit, line, lat, pulse_ok);
    n_cmp++; if ({hit, line, rd} !== {1'b0, 5'd0, 32'h0}) begin n_bad++; $display("FAIL st_miss_resp: got hit=%b line=%0d rd=%h expected 0 0 0", hit, line, rd); end
    n_cmp++; if (lg_addr.size() !== 1) begin n_bad++; $display("FAIL st_miss_nwr: got %0d expected 1", lg_addr.size()); end
    clear_log();
    do_req(1'b0, 32'h1000, '0, rd, hit, line, lat, pulse_ok);
    n_cmp++; if ({hit, rd} !== {1'b0, 32'h1234_5678}) begin n_bad++; $display("FAIL ld_after_st_miss: got hit=%b rd=%h expected 0 12345678", hit, rd); end
    n_cmp++; if (lg_addr.size() !== 4) begin n_bad++; $display("FAIL ld_after_st_miss_nreads: got %0d expected 4", lg_addr.size()); end
`ifdef DCACHE_STATS_EN
    n_cmp++; if ({hit_count, miss_count} !== {32'd3, 32'd5}) begin n_bad++; $display("FAIL stats: got hit=%0d miss=%0d expected 3 5", hit_count, miss_count); end
`endif
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b expected 0", req_ready); end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_req_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_not_accepted: got %0d active cycles expected 0", seen); end
    do_req(1'b0, 32'h40, '0, rd, hit, line, lat, pulse_ok);
    n_cmp++; if ({hit, rd} !== {1'b0, 32'hC0DE0040}) begin n_bad++; $display("FAIL flush_reload: got hit=%b rd=%h expected 0 c0de0040", hit, rd); end
  endtask

  task automatic test_reset_mid_refill();
    int guard, base, seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h340;
    #1;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); #1; guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    base = lg_addr.size();
    guard = 0;
    while (lg_addr.size() == base && guard < 50) begin @(negedge clk); guard++; end
    n_cmp++; if (lg_addr.size() === base) begin n_bad++; $display("FAIL rst_wait_handshake: got timeout expected a refill read"); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if ({req_ready, mem_req_valid, resp_valid} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_outputs: got %b expected 000", {req_ready, mem_req_valid, resp_valid}); end
    reset = 1'b1; stray_resp = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_idle: got %b expected 1", req_ready); end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_req_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rst_stray_ignored: got %0d active cycles expected 0", seen); end
    do_req(1'b0, 32'h40, '0, rd, hit, line, lat, pulse_ok);
    n_cmp++; if ({hit, line, rd} !== {1'b0, 5'd4, 32'hC0DE0040}) begin n_bad++; $display("FAIL rst_reload: got hit=%b line=%0d rd=%h expected 0 4 c0de0040", hit, line, rd); end
    do_req(1'b0, 32'h344, '0, rd, hit, line, lat, pulse_ok);
    n_cmp++; if ({hit, rd} !== {1'b0, 32'hC0DE0344}) begin n_bad++; $display("FAIL rst_abandoned_line: got hit=%b rd=%h expected 0 c0de0344", hit, rd); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_load_hit();
    test_conflict_stall();
    test_store();
    test_flush();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
